// File: rtl/econet_pkg.sv
// -----------------------------------------------------------------------------
// econet_pkg
// Shared constants and types for the Econet receive frame assembler.
//   FCS_GOOD        : CRC-CCITT residue seen after a frame's own FCS bytes
//   BROADCAST_STN   : destination station number addressing every station
//   MIN_FRAME_BYTES : shortest acceptable frame, FCS bytes included
//   rx_state_e      : frame assembler states
// -----------------------------------------------------------------------------
package econet_pkg;

  localparam logic [15:0] FCS_GOOD        = 16'hF0B8;
  localparam logic [7:0]  BROADCAST_STN   = 8'hFF;
  localparam int unsigned MIN_FRAME_BYTES = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } rx_state_e;

endpackage

// File: rtl/econet_frame_ram.sv
// -----------------------------------------------------------------------------
// econet_frame_ram
// Simple dual-port frame buffer, DEPTH x 8, one write port and one registered
// read port. Storage is not reset; only the read register is.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (clears the read register)
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : byte at rd_addr, one cycle latency
// -----------------------------------------------------------------------------
module econet_frame_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // Write port: storage array, intentionally without reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/econet_rx_frame.sv
// -----------------------------------------------------------------------------
// econet_rx_frame
// Frame assembler behind the Econet receiver/FCS pair. Stores one frame in a
// single-frame buffer and holds it for the CPU if the FCS residue is good,
// the frame is long enough and the destination filter passes. A held frame
// stays until frame_ack; frames starting while held are counted as drops.
//
// Build option: define ECONET_RX_ADDR_FILTER_EN to accept only frames whose
// first byte equals station_id or the broadcast station; otherwise every
// station number is accepted and station_id is ignored.
//
// Ports:
//   econet_clk     : sole clock, rising edge
//   reset          : asynchronous active-low reset
//   rx_byte        : received byte, valid with rx_byte_ready
//   rx_byte_ready  : one-cycle byte strobe
//   rx_frame_start : opening flag pulse
//   rx_frame_end   : closing flag pulse
//   rx_fcs         : running FCS, valid with rx_frame_end
//   receiving      : receiver in frame; falling without end = abort
//   station_id     : own station number
//   frame_valid    : good frame held
//   frame_len      : held payload length, FCS excluded
//   rd_addr        : CPU read address
//   rd_data        : buffer byte at rd_addr, one cycle latency
//   frame_ack      : CPU has consumed the held frame
//   drop_count     : saturating count of frames lost while held
// -----------------------------------------------------------------------------
module econet_rx_frame
  import econet_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              econet_clk,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_byte_ready,
  input  logic              rx_frame_start,
  input  logic              rx_frame_end,
  input  logic [15:0]       rx_fcs,
  input  logic              receiving,
  input  logic [7:0]        station_id,
  output logic              frame_valid,
  output logic [ADDR_W:0]   frame_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              frame_ack,
  output logic [7:0]        drop_count
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] MIN_CNT   = (ADDR_W+1)'(MIN_FRAME_BYTES);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] FCS_CNT   = (ADDR_W+1)'(2);

  rx_state_e       state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [7:0]      dest_q, dest_d;
  logic [ADDR_W:0] frame_len_q, frame_len_d;
  logic            frame_valid_q, frame_valid_d;
  logic [7:0]      drop_count_q, drop_count_d;
  logic            receiving_q;

  logic            wr_en_s;
  logic            abort_s;
  logic            filter_ok_s;
  logic            accept_s;

`ifdef ECONET_RX_ADDR_FILTER_EN
  assign filter_ok_s = (dest_q == station_id) || (dest_q == BROADCAST_STN);
`else
  logic unused_filter_s;
  assign unused_filter_s = ^{station_id, dest_q};
  assign filter_ok_s     = 1'b1;
`endif

  // Abort is a falling edge of receiving; rx_frame_end takes priority over it.
  assign abort_s  = receiving_q & ~receiving;
  assign accept_s = (count_q >= MIN_CNT) && (rx_fcs == FCS_GOOD) && filter_ok_s;

  // Next-state, buffer write and output register computation.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    dest_d        = dest_q;
    frame_len_d   = frame_len_q;
    frame_valid_d = frame_valid_q;
    drop_count_d  = drop_count_q;
    wr_en_s       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_frame_start) begin
          state_d = RECV;
          count_d = '0;
        end else begin
          state_d = IDLE;
        end
      end

      RECV: begin
        if (rx_frame_start) begin
          count_d = '0;
        end else if (rx_frame_end) begin
          if (accept_s) begin
            state_d       = HOLD;
            frame_len_d   = count_q - FCS_CNT;
            frame_valid_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (abort_s) begin
          state_d = IDLE;
        end else if (rx_byte_ready) begin
          // A full buffer plus one more byte means the frame cannot be kept.
          if (count_q == DEPTH_CNT) begin
            state_d = DISCARD;
          end else begin
            wr_en_s = 1'b1;
            count_d = count_q + ONE_CNT;
            if (count_q == '0) begin
              dest_d = rx_byte;
            end else begin
              dest_d = dest_q;
            end
          end
        end else begin
          state_d = RECV;
        end
      end

      DISCARD: begin
        if (rx_frame_start) begin
          state_d = RECV;
          count_d = '0;
        end else if (rx_frame_end || abort_s) begin
          state_d = IDLE;
        end else begin
          state_d = DISCARD;
        end
      end

      HOLD: begin
        if (frame_ack) begin
          // Ack beats a coinciding start: the new frame is received, not dropped.
          frame_valid_d = 1'b0;
          if (rx_frame_start) begin
            state_d = RECV;
            count_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (rx_frame_start) begin
          if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
          end else begin
            drop_count_d = drop_count_q;
          end
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d       = IDLE;
        frame_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge econet_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      dest_q        <= 8'h00;
      frame_len_q   <= '0;
      frame_valid_q <= 1'b0;
      drop_count_q  <= 8'h00;
      receiving_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      dest_q        <= dest_d;
      frame_len_q   <= frame_len_d;
      frame_valid_q <= frame_valid_d;
      drop_count_q  <= drop_count_d;
      receiving_q   <= receiving;
    end
  end

  econet_frame_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (econet_clk),
    .rst_n   (reset),
    .wr_en   (wr_en_s),
    .wr_addr (count_q[ADDR_W-1:0]),
    .wr_data (rx_byte),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign frame_valid = frame_valid_q;
  assign frame_len   = frame_len_q;
  assign drop_count  = drop_count_q;

endmodule
